// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the instruction dispatcher: FSM state encoding,
// opcode field constants and the opcode-to-unit mapping.
package dispatch_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam logic [OPCODE_W-1:0] OPCODE_NOP = 4'h0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      DISPATCH,
      WAIT,
      COMPLETE
   } dispatch_state_t;

   // Opcode k (1..NUM_UNITS) targets execution unit k-1.
   function automatic int unsigned opcode_to_unit(input logic [OPCODE_W-1:0] opcode);
      return 32'(opcode) - 32'd1;
   endfunction

endpackage

// File: rtl/instr_dispatch_if.sv
// Fetch/execution-unit handshake bundle between the dispatcher (master) and its environment.
interface instr_dispatch_if #(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned INSTR_W   = 16
);

   logic                 run;
   logic                 instr_valid;
   logic [INSTR_W-1:0]   instr_data;
   logic                 fetch_req;
   logic [NUM_UNITS-1:0] unit_start;
   logic [NUM_UNITS-1:0] unit_done;
   logic [INSTR_W-1:0]   instr_word;
   logic                 busy;
   logic                 retired;
   logic                 illegal_op;
   logic                 timeout;

   modport master (
      input  run, instr_valid, instr_data, unit_done,
      output fetch_req, unit_start, instr_word, busy, retired, illegal_op, timeout
   );

   modport slave (
      output run, instr_valid, instr_data, unit_done,
      input  fetch_req, unit_start, instr_word, busy, retired, illegal_op, timeout
   );

endinterface

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: NOP, illegal (beyond the attached units) or one-hot unit select.
module opcode_decoder
   import dispatch_pkg::*;
#(
   parameter int unsigned NUM_UNITS = 4
) (
   input  logic [OPCODE_W-1:0]  opcode_i,
   output logic                 is_nop_c,
   output logic                 is_illegal_c,
   output logic [NUM_UNITS-1:0] unit_onehot_c
);

   always_comb begin
      is_nop_c      = (opcode_i == OPCODE_NOP);
      is_illegal_c  = (32'(opcode_i) > NUM_UNITS);
      unit_onehot_c = '0;
      if (!is_nop_c && !is_illegal_c) begin
         unit_onehot_c = NUM_UNITS'(1) << opcode_to_unit(opcode_i);
      end
   end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: fetch, decode, start one execution unit, wait for its done, retire.
// Optional WAIT watchdog is compiled in with DISPATCH_WDOG_EN.
module instr_dispatch
   import dispatch_pkg::*;
#(
   parameter int unsigned NUM_UNITS  = 4,
   parameter int unsigned INSTR_W    = 16
`ifdef DISPATCH_WDOG_EN
   , parameter int unsigned WDOG_LIMIT = 15
`endif
) (
   input logic               clk,
   input logic               reset,
   instr_dispatch_if.master  bus
);

   dispatch_state_t      state_q, state_d;
   logic [INSTR_W-1:0]   instr_word_q, instr_word_d;
   logic                 fetch_req_q, fetch_req_d;
   logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
   logic                 busy_q, busy_d;
   logic                 retired_q, retired_d;
   logic                 illegal_op_q, illegal_op_d;
   logic                 timeout_q, timeout_d;

   logic                 dec_nop_c;
   logic                 dec_illegal_c;
   logic [NUM_UNITS-1:0] dec_onehot_c;
   logic                 done_hit_c;

   // instr_word is held from DECODE to COMPLETE, so decoding it also tracks the active unit.
   opcode_decoder #(
      .NUM_UNITS (NUM_UNITS)
   ) u_opcode_decoder (
      .opcode_i      (instr_word_q[INSTR_W-1 -: OPCODE_W]),
      .is_nop_c      (dec_nop_c),
      .is_illegal_c  (dec_illegal_c),
      .unit_onehot_c (dec_onehot_c)
   );

   assign done_hit_c = |(bus.unit_done & dec_onehot_c);

`ifdef DISPATCH_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              wdog_hit_c;

   assign wdog_hit_c = ((32'(wdog_q) + 32'd1) >= WDOG_LIMIT);
`endif

   always_comb begin
      state_d      = state_q;
      instr_word_d = instr_word_q;
      illegal_op_d = 1'b0;
      timeout_d    = 1'b0;
`ifdef DISPATCH_WDOG_EN
      wdog_d       = wdog_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.run) state_d = FETCH;
         end
         FETCH: begin
            if (bus.instr_valid) begin
               instr_word_d = bus.instr_data;
               state_d      = DECODE;
            end
         end
         DECODE: begin
            if (dec_nop_c) begin
               state_d = COMPLETE;
            end else if (dec_illegal_c) begin
               illegal_op_d = 1'b1;
               state_d      = COMPLETE;
            end else begin
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            state_d = WAIT;
`ifdef DISPATCH_WDOG_EN
            wdog_d  = '0;
`endif
         end
         WAIT: begin
            // A done arriving on the limit cycle takes precedence over the abort.
            if (done_hit_c) begin
               state_d = COMPLETE;
`ifdef DISPATCH_WDOG_EN
            end else if (wdog_hit_c) begin
               timeout_d = 1'b1;
               state_d   = COMPLETE;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
`endif
            end
         end
         COMPLETE: begin
            state_d = bus.run ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned with the state.
      fetch_req_d  = (state_d == FETCH);
      unit_start_d = (state_d == DISPATCH) ? dec_onehot_c : '0;
      busy_d       = (state_d != IDLE);
      retired_d    = (state_d == COMPLETE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         instr_word_q <= '0;
         fetch_req_q  <= 1'b0;
         unit_start_q <= '0;
         busy_q       <= 1'b0;
         retired_q    <= 1'b0;
         illegal_op_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         instr_word_q <= instr_word_d;
         fetch_req_q  <= fetch_req_d;
         unit_start_q <= unit_start_d;
         busy_q       <= busy_d;
         retired_q    <= retired_d;
         illegal_op_q <= illegal_op_d;
         timeout_q    <= timeout_d;
      end
   end

`ifdef DISPATCH_WDOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`endif

   assign bus.fetch_req  = fetch_req_q;
   assign bus.unit_start = unit_start_q;
   assign bus.instr_word = instr_word_q;
   assign bus.busy       = busy_q;
   assign bus.retired    = retired_q;
   assign bus.illegal_op = illegal_op_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch with a scoreboard of expected starts/retirements.
module tb_instr_dispatch;

   localparam int unsigned NU = 4;
   localparam int unsigned IW = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   instr_dispatch_if #(.NUM_UNITS(NU), .INSTR_W(IW)) bus ();

   instr_dispatch #(.NUM_UNITS(NU), .INSTR_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [3:0]  start;
      logic        illegal;
   } exp_t;

   exp_t sb_q[$];

   function automatic logic [3:0] model_start(input logic [15:0] instr);
      logic [3:0] op;
      op = instr[15:12];
      case (op)
         4'd1:    return 4'b0001;
         4'd2:    return 4'b0010;
         4'd3:    return 4'b0100;
         4'd4:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic model_illegal(input logic [15:0] instr);
      logic [3:0] op;
      op = instr[15:12];
      return (op > 4'd4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then compare any start/retire against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (bus.unit_start !== 4'b0000) begin
         chk("sb_start_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) chk("sb_start", 32'(bus.unit_start), 32'(sb_q[0].start));
      end
      if (bus.retired === 1'b1) begin
         chk("sb_retire_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_word", 32'(bus.instr_word), 32'(e.instr));
            chk("sb_illegal", 32'(bus.illegal_op), 32'(e.illegal));
         end
      end
   endtask

   // Wait (bounded) for fetch_req, present one instruction word; returns in DECODE.
   task automatic issue(input logic [15:0] instr);
      exp_t e;
      int   n;
      n = 0;
      while (bus.fetch_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("fetch_req_seen", 32'(bus.fetch_req), 32'd1);
      e.instr   = instr;
      e.start   = model_start(instr);
      e.illegal = model_illegal(instr);
      sb_q.push_back(e);
      bus.instr_valid = 1'b1;
      bus.instr_data  = instr;
      tick();
      bus.instr_valid = 1'b0;
      bus.instr_data  = '0;
      chk("decode_busy_nofetch", 32'({bus.busy, bus.fetch_req}), 32'b10);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset           = 1'b1;
      bus.run         = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr_data  = '0;
      bus.unit_done   = '0;
      tick();
      tick();
      chk("rst_outputs", 32'({bus.fetch_req, bus.unit_start, bus.busy, bus.retired,
                              bus.illegal_op, bus.timeout}), 32'd0);
      chk("rst_instr_word", 32'(bus.instr_word), 32'd0);
      reset = 1'b0;

      // MOVI: start two cycles after valid, retire one and fetch two cycles after done
      bus.run = 1'b1;
      issue(16'h1A05);
      tick();
      chk("t1_start", 32'(bus.unit_start), 32'h1);
      tick();
      chk("t1_start_pulse", 32'(bus.unit_start), 32'h0);
      tick();
      tick();
      bus.unit_done = 4'b0001;
      tick();
      chk("t1_retired", 32'(bus.retired), 32'd1);
      chk("t1_fetch_gap", 32'(bus.fetch_req), 32'd0);
      bus.unit_done = 4'b0000;
      tick();
      chk("t1_fetch_after_done", 32'(bus.fetch_req), 32'd1);
      chk("t1_retired_pulse", 32'(bus.retired), 32'd0);

      // NOP then illegal opcode
      issue(16'h0000);
      tick();
      chk("t2_nop_retired", 32'({bus.retired, bus.illegal_op, bus.unit_start}), 32'b100000);
      issue(16'hF000);
      tick();
      chk("t2_ill_retired", 32'({bus.retired, bus.illegal_op, bus.unit_start}), 32'b110000);
      tick();
      chk("t2_ill_pulse", 32'({bus.illegal_op, bus.fetch_req}), 32'b01);

      // Done from the wrong unit is ignored
      issue(16'h2000);
      tick();
      chk("t3_start", 32'(bus.unit_start), 32'h2);
      bus.unit_done = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_wrong_done_wait", 32'({bus.busy, bus.retired}), 32'b10);
      end
      bus.unit_done = 4'b0010;
      tick();
      chk("t3_right_done", 32'(bus.retired), 32'd1);
      bus.unit_done = 4'b0000;
      tick();

      // Reset in the middle of WAIT
      issue(16'h3123);
      tick();
      chk("t4_start", 32'(bus.unit_start), 32'h4);
      tick();
      tick();
      reset = 1'b1;
      tick();
      sb_q.delete();
      chk("t4_rst_outputs", 32'({bus.fetch_req, bus.unit_start, bus.busy, bus.retired,
                                 bus.illegal_op, bus.timeout}), 32'd0);
      chk("t4_rst_word", 32'(bus.instr_word), 32'd0);
      reset   = 1'b0;
      bus.run = 1'b0;
      tick();
      chk("t4_post_rst_start", 32'(bus.unit_start), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_idle_hold", 32'({bus.busy, bus.fetch_req, bus.unit_start}), 32'd0);
      end

      // run drops during WAIT: instruction still completes, then IDLE
      bus.run = 1'b1;
      issue(16'h4000);
      tick();
      chk("t5_start", 32'(bus.unit_start), 32'h8);
      tick();
      bus.run = 1'b0;
      tick();
      chk("t5_still_wait", 32'({bus.busy, bus.retired}), 32'b10);
      bus.unit_done = 4'b1000;
      tick();
      chk("t5_retired", 32'(bus.retired), 32'd1);
      bus.unit_done = 4'b0000;
      tick();
      chk("t5_idle", 32'({bus.busy, bus.fetch_req}), 32'd0);
      tick();
      chk("t5_no_fetch", 32'({bus.busy, bus.fetch_req}), 32'd0);

      // Watchdog: no done for 15 WAIT cycles
      bus.run = 1'b1;
      issue(16'h1000);
      tick();
      tick();
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("t6_wait_early", 32'({bus.busy, bus.retired, bus.timeout}), 32'b100);
      end
      tick();
`ifdef DISPATCH_WDOG_EN
      chk("t6_timeout", 32'({bus.retired, bus.timeout}), 32'b11);
      tick();
      chk("t6_timeout_pulse", 32'({bus.timeout, bus.fetch_req}), 32'b01);
`else
      chk("t6_no_wdog", 32'({bus.busy, bus.retired, bus.timeout}), 32'b100);
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("t6_hold_wait", 32'({bus.busy, bus.retired, bus.timeout}), 32'b100);
      end
      bus.unit_done = 4'b0001;
      tick();
      chk("t6_late_done", 32'(bus.retired), 32'd1);
      bus.unit_done = 4'b0000;
      tick();
`endif

      // Done on the 15th WAIT cycle wins over the watchdog
      issue(16'h1000);
      tick();
      tick();
      for (int i = 0; i < 14; i++) tick();
      bus.unit_done = 4'b0001;
      tick();
      chk("t6_done_at_limit", 32'({bus.retired, bus.timeout}), 32'b10);
      bus.unit_done = 4'b0000;
      bus.run       = 1'b0;
      tick();
      tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
